// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        EXEC   = 2'd2,
        SHOW   = 2'd3
    } seq_state_e;

    localparam logic [SEL_W-1:0] OP_ADD = 2'b00;
    localparam logic [SEL_W-1:0] OP_SUB = 2'b01;
    localparam logic [SEL_W-1:0] OP_SHR = 2'b10;
    localparam logic [SEL_W-1:0] OP_SHL = 2'b11;

endpackage

// File: rtl/key_debounce.sv
// Key synchronizer, optional debounce (ALU_SEQ_DEBOUNCE_EN) and press detector.
// o_press is a one-cycle pulse on the accepted falling edge of the debounced level.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned DEB_W      = 19
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic i_key_n,
    output logic o_press
);

    logic sync1;
    logic sync2;
    logic deb_lvl;
    logic deb_d1;

    // Counter must be able to reach DEB_CYCLES-1
    if ((64'd1 << DEB_W) <= 64'(DEB_CYCLES)) begin : g_deb_w_too_small
        $error("key_debounce: DEB_W too small for DEB_CYCLES");
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= i_key_n;
            sync2 <= sync1;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             deb_q;
    logic [DEB_W-1:0] cnt;

    // Accept a new level only after it has differed for DEB_CYCLES consecutive cycles
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            deb_q <= 1'b1;
            cnt   <= '0;
        end else if (sync2 == deb_q) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            deb_q <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + DEB_W'(1);
        end
    end

    assign deb_lvl = deb_q;
`else
    assign deb_lvl = sync2;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            deb_d1  <= 1'b1;
            o_press <= 1'b0;
        end else begin
            deb_d1  <= deb_lvl;
            o_press <= deb_d1 & ~deb_lvl;
        end
    end

endmodule

// File: rtl/alu_operand_seq.sv
// Three-step operand loader (A, then B+opcode, then execute) feeding a 4-bit ALU.
// Key debounce is compiled in when ALU_SEQ_DEBOUNCE_EN is defined.
module alu_operand_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned DEB_W      = 19
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              i_key_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic [DATA_W-1:0] i_res,
    input  logic              i_ovf,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b,
    output logic [SEL_W-1:0]  o_sel,
    output logic [DATA_W-1:0] o_res,
    output logic              o_ovf,
    output logic              o_done,
    output logic [1:0]        o_state
);

    logic press;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .DEB_W     (DEB_W)
    ) u_key (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .i_key_n(i_key_n),
        .o_press(press)
    );

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [DATA_W-1:0] a_d;
    logic [DATA_W-1:0] b_d;
    logic [SEL_W-1:0]  sel_d;
    logic [DATA_W-1:0] res_d;
    logic              ovf_d;
    logic              done_d;

    always_comb begin
        state_d = state_q;
        a_d     = o_a;
        b_d     = o_b;
        sel_d   = o_sel;
        res_d   = o_res;
        ovf_d   = o_ovf;
        done_d  = o_done;
        case (state_q)
            WAIT_A: begin
                if (press) begin
                    a_d     = i_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (press) begin
                    b_d     = i_data;
                    sel_d   = i_sel;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Shifts never report overflow, whatever the ALU drives
                res_d   = i_res;
                ovf_d   = ((o_sel == OP_ADD) || (o_sel == OP_SUB)) ? i_ovf : 1'b0;
                done_d  = 1'b1;
                state_d = SHOW;
            end
            SHOW: begin
                if (press) begin
                    done_d  = 1'b0;
                    state_d = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= WAIT_A;
            o_a     <= '0;
            o_b     <= '0;
            o_sel   <= '0;
            o_res   <= '0;
            o_ovf   <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_a     <= a_d;
            o_b     <= b_d;
            o_sel   <= sel_d;
            o_res   <= res_d;
            o_ovf   <= ovf_d;
            o_done  <= done_d;
        end
    end

    assign o_state = state_q;

endmodule
